// File: rtl/sound_comm_mailbox_if.sv
// Mailbox bundle between 68k bus decode / io_sound (master) and the mailbox controller (slave).
// Pure wiring, no latency; flow control is strobe edges plus full/avail status, no stall path.
interface sound_comm_mailbox_if #(
    parameter int DW = 8
);
    logic          m68k_wr_b;
    logic          m68k_rd_b;
    logic [DW-1:0] m68k_din;
    logic [DW-1:0] m68k_dout;
    logic          snd_wr_b;
    logic          snd_rd_b;
    logic [DW-1:0] snd_din;
    logic [DW-1:0] snd_dout;
    logic          sndnmi_b;
    logic          cmd_full;
    logic          resp_full;
    logic          resp_avail;
    logic          ovr_clr;
    logic          cmd_ovr;
    logic          resp_ovr;

    modport slave (
        input  m68k_wr_b, m68k_rd_b, m68k_din, snd_wr_b, snd_rd_b, snd_din, ovr_clr,
        output m68k_dout, snd_dout, sndnmi_b, cmd_full, resp_full, resp_avail, cmd_ovr, resp_ovr
    );

    modport master (
        output m68k_wr_b, m68k_rd_b, m68k_din, snd_wr_b, snd_rd_b, snd_din, ovr_clr,
        input  m68k_dout, snd_dout, sndnmi_b, cmd_full, resp_full, resp_avail, cmd_ovr, resp_ovr
    );
endinterface

// File: rtl/sound_comm_mailbox.sv
// 68k <-> 6502 sound mailbox: command/response channels plus NMI sequencer; SNDCOMM_FIFO_EN selects FIFO channels.
// Status/head outputs update on the clk after a strobe rising edge; NMI pulse follows the command by 1 clk.
// No backpressure: pushes into a full channel are dropped and flagged in the sticky overrun bit.
module sound_comm_chan #(
    parameter int DW    = 8,
    parameter int DEPTH = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    input  logic          ovr_clr,
    output logic [DW-1:0] dout_q,
    output logic          full_q,
    output logic          avail_q,
    output logic          ovr_q
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NE = 1 << PW;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    logic [DW-1:0] mem_q [NE];
    logic [DW-1:0] mem_d [NE];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d, count_mid;
    logic [DW-1:0] dout_d;
    logic          full_d, avail_d, ovr_d;
    logic          do_pop, do_push;

    always_comb begin
        // Pop is resolved first so a full channel can accept a same-clk push.
        do_pop    = pop && (count_q != '0);
        count_mid = count_q - CW'(do_pop);
        do_push   = push && (count_mid != DEPTH_C);
        count_d   = count_mid + CW'(do_push);
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        mem_d     = mem_q;
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + PW'(1);
        end
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + PW'(1);
        end
        ovr_d = ovr_q;
        if (ovr_clr) begin
            ovr_d = 1'b0;
        end
        if (push && !do_push) begin
            ovr_d = 1'b1;
        end
        full_d  = (count_d == DEPTH_C);
        avail_d = (count_d != '0);
        dout_d  = avail_d ? mem_d[rd_ptr_d] : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NE; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            full_q   <= 1'b0;
            avail_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            full_q   <= full_d;
            avail_q  <= avail_d;
            ovr_q    <= ovr_d;
        end
    end
endmodule

module sound_comm_mailbox #(
    parameter int DW         = 8,
    parameter int NMI_WIDTH  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    sound_comm_mailbox_if.slave  bus
);
`ifdef SNDCOMM_FIFO_EN
    localparam int DEPTH = FIFO_DEPTH;
`else
    localparam int DEPTH = (FIFO_DEPTH > 0) ? 1 : 1;
`endif
    localparam int NCW = $clog2(NMI_WIDTH) + 1;
    localparam logic [NCW-1:0] NMI_LAST = NCW'(NMI_WIDTH - 1);

    typedef enum logic [1:0] {NMI_IDLE, NMI_PULSE, NMI_WAIT} nmi_state_e;

    logic          m68k_wr_q, m68k_wr_d, m68k_rd_q, m68k_rd_d;
    logic          snd_wr_q, snd_wr_d, snd_rd_q, snd_rd_d;
    logic [DW-1:0] cmd_cap_q, cmd_cap_d, resp_cap_q, resp_cap_d;
    logic          m68k_wr_ev, m68k_rd_ev, snd_wr_ev, snd_rd_ev;
    logic          cmd_avail;
    nmi_state_e    state_q, state_d;
    logic [NCW-1:0] ncnt_q, ncnt_d;
    logic          nmi_b_q, nmi_b_d;

    always_comb begin
        m68k_wr_d  = bus.m68k_wr_b;
        m68k_rd_d  = bus.m68k_rd_b;
        snd_wr_d   = bus.snd_wr_b;
        snd_rd_d   = bus.snd_rd_b;
        m68k_wr_ev = !m68k_wr_q && bus.m68k_wr_b;
        m68k_rd_ev = !m68k_rd_q && bus.m68k_rd_b;
        snd_wr_ev  = !snd_wr_q && bus.snd_wr_b;
        snd_rd_ev  = !snd_rd_q && bus.snd_rd_b;
        // Write data tracks the bus only while the strobe is low; the edge cycle commits the last sample.
        cmd_cap_d  = bus.m68k_wr_b ? cmd_cap_q : bus.m68k_din;
        resp_cap_d = bus.snd_wr_b ? resp_cap_q : bus.snd_din;
    end

    always_comb begin
        state_d = state_q;
        ncnt_d  = ncnt_q;
        case (state_q)
            NMI_IDLE: begin
                if (cmd_avail) begin
                    state_d = NMI_PULSE;
                    ncnt_d  = '0;
                end
            end
            NMI_PULSE: begin
                if (ncnt_q == NMI_LAST) begin
                    state_d = NMI_WAIT;
                end else begin
                    ncnt_d = ncnt_q + NCW'(1);
                end
            end
            NMI_WAIT: begin
                if (snd_rd_ev) begin
                    state_d = NMI_IDLE;
                end
            end
            default: state_d = NMI_IDLE;
        endcase
        nmi_b_d = (state_d != NMI_PULSE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m68k_wr_q  <= 1'b1;
            m68k_rd_q  <= 1'b1;
            snd_wr_q   <= 1'b1;
            snd_rd_q   <= 1'b1;
            cmd_cap_q  <= '0;
            resp_cap_q <= '0;
            state_q    <= NMI_IDLE;
            ncnt_q     <= '0;
            nmi_b_q    <= 1'b1;
        end else begin
            m68k_wr_q  <= m68k_wr_d;
            m68k_rd_q  <= m68k_rd_d;
            snd_wr_q   <= snd_wr_d;
            snd_rd_q   <= snd_rd_d;
            cmd_cap_q  <= cmd_cap_d;
            resp_cap_q <= resp_cap_d;
            state_q    <= state_d;
            ncnt_q     <= ncnt_d;
            nmi_b_q    <= nmi_b_d;
        end
    end

    assign bus.sndnmi_b = nmi_b_q;

    sound_comm_chan #(.DW(DW), .DEPTH(DEPTH)) u_cmd (
        .clk     (clk),
        .reset   (reset),
        .push    (m68k_wr_ev),
        .pop     (snd_rd_ev),
        .din     (cmd_cap_q),
        .ovr_clr (bus.ovr_clr),
        .dout_q  (bus.snd_dout),
        .full_q  (bus.cmd_full),
        .avail_q (cmd_avail),
        .ovr_q   (bus.cmd_ovr)
    );

    sound_comm_chan #(.DW(DW), .DEPTH(DEPTH)) u_resp (
        .clk     (clk),
        .reset   (reset),
        .push    (snd_wr_ev),
        .pop     (m68k_rd_ev),
        .din     (resp_cap_q),
        .ovr_clr (bus.ovr_clr),
        .dout_q  (bus.m68k_dout),
        .full_q  (bus.resp_full),
        .avail_q (bus.resp_avail),
        .ovr_q   (bus.resp_ovr)
    );
endmodule

// File: tb/tb_sound_comm_mailbox.sv
// Bench for sound_comm_mailbox: directed scenarios plus random strobe traffic against a queue model.
`timescale 1ns/1ps
module tb_sound_comm_mailbox;
    localparam int NMI_WIDTH = 4;
`ifdef SNDCOMM_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic clk = 1'b0;
    logic reset;

    sound_comm_mailbox_if #(.DW(8)) bus();

    sound_comm_mailbox #(.DW(8), .NMI_WIDTH(NMI_WIDTH), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int run    = 0;

    logic [7:0] cmd_m[$];
    logic [7:0] resp_m[$];
    bit         cmd_ovr_m;
    bit         resp_ovr_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Every low run of sndnmi_b outside reset must be exactly NMI_WIDTH clocks.
    always @(negedge clk) begin
        if (reset) begin
            run = 0;
        end else if (bus.sndnmi_b === 1'b0) begin
            if (run == 0) pulses++;
            run++;
        end else if (run != 0) begin
            chk("nmi_width", run, NMI_WIDTH);
            run = 0;
        end
    end

    task automatic cmd_push(input logic [7:0] d);
        if (cmd_m.size() == DEPTH) cmd_ovr_m = 1'b1;
        else cmd_m.push_back(d);
    endtask

    task automatic resp_push(input logic [7:0] d);
        if (resp_m.size() == DEPTH) resp_ovr_m = 1'b1;
        else resp_m.push_back(d);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":snd_dout"}, bus.snd_dout, (cmd_m.size() != 0) ? cmd_m[0] : 8'h00);
        chk({tag, ":cmd_full"}, bus.cmd_full, cmd_m.size() == DEPTH);
        chk({tag, ":m68k_dout"}, bus.m68k_dout, (resp_m.size() != 0) ? resp_m[0] : 8'h00);
        chk({tag, ":resp_full"}, bus.resp_full, resp_m.size() == DEPTH);
        chk({tag, ":resp_avail"}, bus.resp_avail, resp_m.size() != 0);
        chk({tag, ":cmd_ovr"}, bus.cmd_ovr, cmd_ovr_m);
        chk({tag, ":resp_ovr"}, bus.resp_ovr, resp_ovr_m);
    endtask

    // cw: 68k write, cr: 6502 read, rw: 6502 write, rr: 68k read; all rise together.
    task automatic do_op(input string tag, input bit cw, input bit cr, input bit rw, input bit rr,
                         input bit clr, input logic [7:0] cd, input logic [7:0] rd, input int len);
        @(negedge clk);
        bus.m68k_din = cd;
        bus.snd_din  = rd;
        if (cw) bus.m68k_wr_b = 1'b0;
        if (cr) bus.snd_rd_b  = 1'b0;
        if (rw) bus.snd_wr_b  = 1'b0;
        if (rr) bus.m68k_rd_b = 1'b0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (cr) chk({tag, ":cmd_head_low"}, bus.snd_dout, (cmd_m.size() != 0) ? cmd_m[0] : 8'h00);
            if (rr) chk({tag, ":resp_head_low"}, bus.m68k_dout, (resp_m.size() != 0) ? resp_m[0] : 8'h00);
        end
        bus.m68k_wr_b = 1'b1;
        bus.snd_rd_b  = 1'b1;
        bus.snd_wr_b  = 1'b1;
        bus.m68k_rd_b = 1'b1;
        bus.ovr_clr   = clr;
        bus.m68k_din  = 8'($urandom);
        bus.snd_din   = 8'($urandom);
        if (clr) begin
            cmd_ovr_m  = 1'b0;
            resp_ovr_m = 1'b0;
        end
        if (cr && cmd_m.size() != 0) void'(cmd_m.pop_front());
        if (cw) cmd_push(cd);
        if (rr && resp_m.size() != 0) void'(resp_m.pop_front());
        if (rw) resp_push(rd);
        @(negedge clk);
        bus.ovr_clr = 1'b0;
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.m68k_wr_b = 1'b1;
        bus.m68k_rd_b = 1'b1;
        bus.snd_wr_b  = 1'b1;
        bus.snd_rd_b  = 1'b1;
        bus.ovr_clr   = 1'b0;
        cmd_m.delete();
        resp_m.delete();
        cmd_ovr_m  = 1'b0;
        resp_ovr_m = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        logic [7:0] v;
        reset = 1'b1;
        bus.m68k_wr_b = 1'b1;
        bus.m68k_rd_b = 1'b1;
        bus.snd_wr_b  = 1'b1;
        bus.snd_rd_b  = 1'b1;
        bus.m68k_din  = 8'h00;
        bus.snd_din   = 8'h00;
        bus.ovr_clr   = 1'b0;
        cmd_ovr_m  = 1'b0;
        resp_ovr_m = 1'b0;
        repeat (3) @(negedge clk);
        check_all("reset");
        chk("reset_nmi", bus.sndnmi_b, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        check_all("post_reset");

        // Single command, one NMI pulse, none after the 6502 reads it.
        p0 = pulses;
        do_op("wr_a5", 1, 0, 0, 0, 0, 8'hA5, 8'h00, 2);
        repeat (12) @(negedge clk);
        chk("nmi_one_pulse", pulses - p0, 1);
        chk("nmi_wait_high", bus.sndnmi_b, 1'b1);
        do_op("rd_a5", 0, 1, 0, 0, 0, 8'h00, 8'h00, 2);
        repeat (12) @(negedge clk);
        chk("nmi_no_pulse_after_read", pulses - p0, 1);
        chk("nmi_high_after_read", bus.sndnmi_b, 1'b1);

        // Overrun, clear, and clear colliding with a new overrun.
        do_reset();
        do_op("wr_11", 1, 0, 0, 0, 0, 8'h11, 8'h00, 1);
        do_op("wr_22", 1, 0, 0, 0, 0, 8'h22, 8'h00, 1);
        while (cmd_m.size() < DEPTH) do_op("fill_cmd", 1, 0, 0, 0, 0, 8'h40, 8'h00, 1);
        do_op("ovr_set", 1, 0, 0, 0, 0, 8'h55, 8'h00, 1);
        do_op("ovr_clr_vs_ovr", 1, 0, 0, 0, 1, 8'h66, 8'h00, 1);
        do_op("ovr_clr", 0, 0, 0, 0, 1, 8'h00, 8'h00, 1);

        // Fill then drain: order preserved and one NMI per pop.
        do_reset();
        p0 = pulses;
        for (int i = 0; i < DEPTH; i++) begin
            v = (DEPTH == 1) ? 8'hA5 : 8'(i + 1);
            do_op("fill", 1, 0, 0, 0, 0, v, 8'h00, 1);
        end
        chk("full_after_fill", bus.cmd_full, 1'b1);
        repeat (10) @(negedge clk);
        for (int i = 0; i < DEPTH; i++) begin
            v = (DEPTH == 1) ? 8'hA5 : 8'(i + 1);
            chk("nmi_count", pulses - p0, i + 1);
            chk("pop_order", bus.snd_dout, v);
            do_op("drain", 0, 1, 0, 0, 0, 8'h00, 8'h00, 2);
            repeat (10) @(negedge clk);
        end
        chk("nmi_total", pulses - p0, DEPTH);

        // Response channel, including full with same-clk push and pop.
        do_reset();
        do_op("resp_5a", 0, 0, 1, 0, 0, 8'h00, 8'h5A, 2);
        chk("resp_avail_set", bus.resp_avail, 1'b1);
        do_op("resp_rd", 0, 0, 0, 1, 0, 8'h00, 8'h00, 2);
        chk("resp_avail_clr", bus.resp_avail, 1'b0);
        for (int i = 0; i < DEPTH; i++) do_op("resp_fill", 0, 0, 1, 0, 0, 8'h00, 8'(8'h70 + i), 1);
        do_op("resp_simul", 0, 0, 1, 1, 0, 8'h00, 8'h7F, 2);
        chk("resp_simul_full", bus.resp_full, 1'b1);
        chk("resp_simul_ovr", bus.resp_ovr, 1'b0);

        // Reset landing in the middle of an NMI pulse.
        do_reset();
        p0 = pulses;
        @(negedge clk); bus.m68k_din = 8'h31; bus.m68k_wr_b = 1'b0;
        @(negedge clk); bus.m68k_wr_b = 1'b1; cmd_push(8'h31);
        @(negedge clk); bus.m68k_din = 8'h32; bus.m68k_wr_b = 1'b0;
        @(negedge clk); bus.m68k_wr_b = 1'b1; cmd_push(8'h32);
        @(negedge clk);
        chk("mid_pulse_low", bus.sndnmi_b, 1'b0);
        reset = 1'b1;
        #1;
        chk("rst_mid_nmi", bus.sndnmi_b, 1'b1);
        chk("rst_mid_cmd_full", bus.cmd_full, 1'b0);
        chk("rst_mid_snd_dout", bus.snd_dout, 8'h00);
        chk("rst_mid_cmd_ovr", bus.cmd_ovr, 1'b0);
        cmd_m.delete();
        cmd_ovr_m = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("no_pulse_after_reset", pulses - p0, 1);
        check_all("after_mid_reset");

        // Random traffic on both channels.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            do_op("rand", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom % 5) == 0, 8'($urandom), 8'($urandom), $urandom_range(1, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
